// File: rtl/wb_int_ctrl_if.sv
// Bus bundle between the MEM/WB pipeline register, the front end and the writeback/interrupt controller.
// The slave side is the controller; the master side drives the WB fields and the interrupt lines.
interface wb_int_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             en;
   logic             RegWrite_in;
   logic             MemToReg_in;
   logic             ecall_in;
   logic             uret_in;
   logic             Int_Enter_in;
   logic             CSRWrite_in;
   logic             IEWrite_in;
   logic             EPCWrite_in;
   logic             IEWriteData_in;
   logic [4:0]       WriteRegNo_in;
   logic [WIDTH-1:0] MemData_in;
   logic [WIDTH-1:0] ALU_Result_in;
   logic [WIDTH-1:0] a0_in;
   logic [WIDTH-1:0] a7_in;
   logic [WIDTH-1:0] EPCWriteData_in;
   logic [2:0]       IRS_in;
   logic [2:0]       irq_raw;
   logic             Int_Ack;

   logic             RegWrite_out;
   logic [4:0]       WriteRegNo_out;
   logic [WIDTH-1:0] WriteData_out;
   logic             IE_out;
   logic [WIDTH-1:0] EPC_out;
   logic             Int_Req;
   logic [WIDTH-1:0] Int_Vec;
   logic [2:0]       IRS_req;
   logic             halt_out;
   logic             print_valid;
   logic [WIDTH-1:0] print_data;

   modport master (
      output en, RegWrite_in, MemToReg_in, ecall_in, uret_in, Int_Enter_in,
             CSRWrite_in, IEWrite_in, EPCWrite_in, IEWriteData_in, WriteRegNo_in,
             MemData_in, ALU_Result_in, a0_in, a7_in, EPCWriteData_in, IRS_in,
             irq_raw, Int_Ack,
      input  RegWrite_out, WriteRegNo_out, WriteData_out, IE_out, EPC_out,
             Int_Req, Int_Vec, IRS_req, halt_out, print_valid, print_data
   );

   modport slave (
      input  en, RegWrite_in, MemToReg_in, ecall_in, uret_in, Int_Enter_in,
             CSRWrite_in, IEWrite_in, EPCWrite_in, IEWriteData_in, WriteRegNo_in,
             MemData_in, ALU_Result_in, a0_in, a7_in, EPCWriteData_in, IRS_in,
             irq_raw, Int_Ack,
      output RegWrite_out, WriteRegNo_out, WriteData_out, IE_out, EPC_out,
             Int_Req, Int_Vec, IRS_req, halt_out, print_valid, print_data
   );
endinterface

// File: rtl/wb_int_ctrl.sv
// Writeback-stage controller: register-file writeback mux, IE/EPC commit, ecall halt/print,
// and edge-captured, prioritised external interrupts with a held request/ack handshake.
module wb_int_ctrl #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0040
) (
   input logic         clk,
   input logic         rst,
   wb_int_ctrl_if.slave bus
);

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_t;

   state_t           state, state_nxt;
   logic             commit;
   logic             req_go;
   logic             inflight;
   logic [2:0]       irq_prev, pending, rise, clr;
   logic [2:0]       top_src;
   logic [1:0]       top_idx;
   logic [WIDTH-1:0] top_vec;

   assign commit = bus.en & ~bus.halt_out;

   assign bus.WriteRegNo_out = bus.WriteRegNo_in;
   assign bus.WriteData_out  = bus.MemToReg_in ? bus.MemData_in : bus.ALU_Result_in;
   assign bus.RegWrite_out   = bus.RegWrite_in & commit & (bus.WriteRegNo_in != 5'd0);
   assign bus.Int_Req        = (state == S_REQ);

   assign rise = bus.irq_raw & ~irq_prev;
   assign clr  = (commit & bus.Int_Enter_in) ? bus.IRS_in : 3'b000;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      top_src = 3'b000;
      top_idx = 2'd0;
      if (pending[2]) begin
         top_src = 3'b100;
         top_idx = 2'd2;
      end else if (pending[1]) begin
         top_src = 3'b010;
         top_idx = 2'd1;
      end else if (pending[0]) begin
         top_src = 3'b001;
         top_idx = 2'd0;
      end
   end

   assign top_vec = VEC_BASE + WIDTH'(top_idx) * VEC_STRIDE;

   always_comb begin
      state_nxt = state;
      req_go    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.IE_out & (|pending) & ~inflight & ~bus.halt_out) begin
               state_nxt = S_REQ;
               req_go    = 1'b1;
            end
         end
         S_REQ: begin
            // Once raised, the request is held regardless of IE or newer arrivals until acked.
            if (bus.Int_Ack) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: reset is asynchronous and covers every control/CSR register, so a reset mid-handshake clears at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.IE_out      <= 1'b1;
         bus.EPC_out     <= '0;
         bus.halt_out    <= 1'b0;
         bus.print_valid <= 1'b0;
         bus.print_data  <= '0;
         bus.IRS_req     <= 3'b000;
         bus.Int_Vec     <= '0;
         irq_prev        <= 3'b000;
         pending         <= 3'b000;
         inflight        <= 1'b0;
      end else begin
         irq_prev        <= bus.irq_raw;
         pending         <= (pending & ~clr) | rise;
         bus.print_valid <= 1'b0;

         if (commit & bus.CSRWrite_in) begin
            if (bus.IEWrite_in)  bus.IE_out  <= bus.IEWriteData_in;
            if (bus.EPCWrite_in) bus.EPC_out <= bus.EPCWriteData_in;
         end

         if (commit & bus.ecall_in) begin
            if (bus.a7_in == WIDTH'(10)) begin
               bus.halt_out <= 1'b1;
            end else begin
               bus.print_valid <= 1'b1;
               bus.print_data  <= bus.a0_in;
            end
         end

         if (commit & (bus.Int_Enter_in | bus.uret_in)) inflight <= 1'b0;

         if (req_go) begin
            bus.IRS_req <= top_src;
            bus.Int_Vec <= top_vec;
         end else if ((state == S_REQ) && bus.Int_Ack) begin
            bus.IRS_req <= 3'b000;
            inflight    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_int_ctrl.sv
// Self-checking bench for wb_int_ctrl: table-driven writeback vectors plus handshake,
// priority, IE gating, ecall and reset sequences, with a scoreboard of expected requests.
module tb_wb_int_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   wb_int_ctrl_if #(.WIDTH(32)) bus ();

   wb_int_ctrl #(
      .WIDTH     (32),
      .VEC_BASE  (32'h0000_0100),
      .VEC_STRIDE(32'h0000_0040)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic        en;
      logic [4:0]  rd;
      logic [31:0] mem;
      logic [31:0] alu;
      logic        exp_rw;
      logic [31:0] exp_wd;
   } wb_vec_t;

   typedef struct packed {
      logic        rw;
      logic [31:0] wd;
   } wb_exp_t;

   typedef struct packed {
      logic [2:0]  irs;
      logic [31:0] vec;
   } req_exp_t;

   wb_vec_t  vecs [4];
   wb_exp_t  wb_q [$];
   req_exp_t req_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.en              = 1'b1;
      bus.RegWrite_in     = 1'b0;
      bus.MemToReg_in     = 1'b0;
      bus.ecall_in        = 1'b0;
      bus.uret_in         = 1'b0;
      bus.Int_Enter_in    = 1'b0;
      bus.CSRWrite_in     = 1'b0;
      bus.IEWrite_in      = 1'b0;
      bus.EPCWrite_in     = 1'b0;
      bus.IEWriteData_in  = 1'b0;
      bus.WriteRegNo_in   = 5'd0;
      bus.MemData_in      = '0;
      bus.ALU_Result_in   = '0;
      bus.a0_in           = '0;
      bus.a7_in           = '0;
      bus.EPCWriteData_in = '0;
      bus.IRS_in          = 3'b000;
      bus.Int_Ack         = 1'b0;
   endtask

   // One committed WB cycle carrying CSR fields (and optionally Int_Enter/uret).
   task automatic retire(input logic int_enter, input logic uret, input logic ie_we,
                         input logic ie_d, input logic epc_we, input logic [31:0] epc_d,
                         input logic [2:0] irs);
      bus.en              = 1'b1;
      bus.CSRWrite_in     = 1'b1;
      bus.Int_Enter_in    = int_enter;
      bus.uret_in         = uret;
      bus.IEWrite_in      = ie_we;
      bus.IEWriteData_in  = ie_d;
      bus.EPCWrite_in     = epc_we;
      bus.EPCWriteData_in = epc_d;
      bus.IRS_in          = irs;
      tick();
      bus.CSRWrite_in     = 1'b0;
      bus.Int_Enter_in    = 1'b0;
      bus.uret_in         = 1'b0;
      bus.IEWrite_in      = 1'b0;
      bus.EPCWrite_in     = 1'b0;
      bus.IRS_in          = 3'b000;
   endtask

   task automatic ack();
      bus.Int_Ack = 1'b1;
      tick();
      bus.Int_Ack = 1'b0;
      check("ack_req_low", 32'(bus.Int_Req), 0);
      check("ack_irs_zero", 32'(bus.IRS_req), 0);
   endtask

   task automatic expect_req(input string name);
      req_exp_t e;
      check({name, "_req"}, 32'(bus.Int_Req), 1);
      if (req_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'(req_q.size()), 1);
      end else begin
         e = req_q.pop_front();
         check({name, "_irs"}, 32'(bus.IRS_req), 32'(e.irs));
         check({name, "_vec"}, bus.Int_Vec, e.vec);
      end
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_int_req"}, 32'(bus.Int_Req), 0);
      check({name, "_ie"}, 32'(bus.IE_out), 1);
      check({name, "_epc"}, bus.EPC_out, 0);
      check({name, "_halt"}, 32'(bus.halt_out), 0);
      check({name, "_pvalid"}, 32'(bus.print_valid), 0);
      check({name, "_pdata"}, bus.print_data, 0);
      check({name, "_irs"}, 32'(bus.IRS_req), 0);
      check({name, "_vec"}, bus.Int_Vec, 0);
   endtask

   initial begin
      wb_exp_t got;

      vecs[0] = '{rw: 1'b1, m2r: 1'b0, en: 1'b1, rd: 5'd5, mem: 32'h0, alu: 32'h1234,
                  exp_rw: 1'b1, exp_wd: 32'h1234};
      vecs[1] = '{rw: 1'b1, m2r: 1'b1, en: 1'b1, rd: 5'd5, mem: 32'hBEEF, alu: 32'h1234,
                  exp_rw: 1'b1, exp_wd: 32'hBEEF};
      vecs[2] = '{rw: 1'b1, m2r: 1'b0, en: 1'b1, rd: 5'd0, mem: 32'h0, alu: 32'h5555,
                  exp_rw: 1'b0, exp_wd: 32'h5555};
      vecs[3] = '{rw: 1'b1, m2r: 1'b1, en: 1'b0, rd: 5'd7, mem: 32'hCAFE, alu: 32'h1,
                  exp_rw: 1'b0, exp_wd: 32'hCAFE};

      clear_inputs();
      bus.irq_raw = 3'b000;
      rst = 1'b1;
      #3;
      check_reset_values("reset");
      tick();
      tick();
      rst = 1'b0;

      // Writeback table
      for (int i = 0; i < 4; i++) begin
         bus.RegWrite_in   = vecs[i].rw;
         bus.MemToReg_in   = vecs[i].m2r;
         bus.en            = vecs[i].en;
         bus.WriteRegNo_in = vecs[i].rd;
         bus.MemData_in    = vecs[i].mem;
         bus.ALU_Result_in = vecs[i].alu;
         wb_q.push_back('{rw: vecs[i].exp_rw, wd: vecs[i].exp_wd});
         #1;
         got = wb_q.pop_front();
         check($sformatf("wb%0d_regwrite", i), 32'(bus.RegWrite_out), 32'(got.rw));
         check($sformatf("wb%0d_data", i), bus.WriteData_out, got.wd);
         check($sformatf("wb%0d_regno", i), 32'(bus.WriteRegNo_out), 32'(vecs[i].rd));
         #1;
      end
      clear_inputs();

      // Single IRQ: two-edge latency, stable hold, ack, Int_Enter retire
      tick();
      bus.irq_raw = 3'b010;
      req_q.push_back('{irs: 3'b010, vec: 32'h140});
      tick();
      check("single_edge_k_req", 32'(bus.Int_Req), 0);
      check("single_pending", 32'(dut.pending), 32'b010);
      tick();
      expect_req("single");
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("single_hold%0d_req", i), 32'(bus.Int_Req), 1);
         check($sformatf("single_hold%0d_irs", i), 32'(bus.IRS_req), 32'b010);
         check($sformatf("single_hold%0d_vec", i), bus.Int_Vec, 32'h140);
      end
      ack();
      tick();
      tick();
      check("inflight_blocks", 32'(bus.Int_Req), 0);
      retire(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 3'b010);
      check("enter_ie", 32'(bus.IE_out), 0);
      check("enter_epc", bus.EPC_out, 32'h80);
      check("enter_pending", 32'(dut.pending), 0);
      bus.irq_raw = 3'b000;

      // Priority: sources 0 and 2 together
      retire(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 3'b000);
      check("uret_ie", 32'(bus.IE_out), 1);
      bus.irq_raw = 3'b101;
      req_q.push_back('{irs: 3'b100, vec: 32'h180});
      tick();
      tick();
      expect_req("prio_hi");
      ack();
      retire(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 3'b100);
      check("prio_pending_lo", 32'(dut.pending), 32'b001);
      tick();
      check("prio_ie_off_noreq", 32'(bus.Int_Req), 0);
      req_q.push_back('{irs: 3'b001, vec: 32'h100});
      retire(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 3'b000);
      check("prio_uret_edge_noreq", 32'(bus.Int_Req), 0);
      tick();
      expect_req("prio_lo");
      ack();
      retire(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 3'b001);
      bus.irq_raw = 3'b000;

      // IE gating, then IE cleared while requesting
      tick();
      bus.irq_raw = 3'b001;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("ie_gate%0d", i), 32'(bus.Int_Req), 0);
      end
      req_q.push_back('{irs: 3'b001, vec: 32'h100});
      retire(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 3'b000);
      check("ie_set_edge_noreq", 32'(bus.Int_Req), 0);
      tick();
      expect_req("ie_set");
      retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000);
      check("ie_clear_ie", 32'(bus.IE_out), 0);
      check("ie_clear_req_held", 32'(bus.Int_Req), 1);
      ack();
      retire(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h400, 3'b001);
      check("ie_restore", 32'(bus.IE_out), 1);
      check("ie_epc", bus.EPC_out, 32'h400);

      // Ecall print then halt
      bus.a7_in    = 32'd1;
      bus.a0_in    = 32'h2A;
      bus.ecall_in = 1'b1;
      tick();
      bus.ecall_in = 1'b0;
      check("print_valid", 32'(bus.print_valid), 1);
      check("print_data", bus.print_data, 32'h2A);
      tick();
      check("print_one_cycle", 32'(bus.print_valid), 0);
      bus.a7_in    = 32'd10;
      bus.ecall_in = 1'b1;
      tick();
      bus.ecall_in = 1'b0;
      check("halt_set", 32'(bus.halt_out), 1);
      check("halt_no_print", 32'(bus.print_valid), 0);
      bus.RegWrite_in   = 1'b1;
      bus.WriteRegNo_in = 5'd3;
      #1;
      check("halt_regwrite", 32'(bus.RegWrite_out), 0);
      retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000);
      check("halt_blocks_csr", 32'(bus.IE_out), 1);
      bus.irq_raw = 3'b010;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("halt_noreq%0d", i), 32'(bus.Int_Req), 0);
      end
      check("halt_sticky", 32'(bus.halt_out), 1);
      clear_inputs();

      // Reset mid-request
      rst = 1'b1;
      #2;
      rst = 1'b0;
      check("rst_clears_halt", 32'(bus.halt_out), 0);
      req_q.push_back('{irs: 3'b010, vec: 32'h140});
      tick();
      tick();
      expect_req("pre_rst");
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("mid_rst");
      tick();
      rst = 1'b0;
      check("sb_drained", 32'(req_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_int_ctrl.md
# wb_int_ctrl

Writeback-stage controller of the interrupt pipeline, directly downstream of the MEM/WB pipeline register. It consumes the registered WB fields and performs three jobs: register-file writeback muxing, CSR state (IE, EPC) commit, and ecall service (halt/print). It also latches and prioritises three external interrupt lines and issues a held request/acknowledge handshake to the front end.

## Interface
- WIDTH, 32, datapath width
- VEC_BASE, 32'h0000_0100, handler address of source 0
- VEC_STRIDE, 32'h0000_0040, address gap between source handlers
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  WB stage enable; low = stall, no state commit
- RegWrite_in, MemToReg_in, ecall_in, uret_in, Int_Enter_in, CSRWrite_in, IEWrite_in, EPCWrite_in, IEWriteData_in  in  1 each  WB control fields
- WriteRegNo_in  in  5  destination register
- MemData_in, ALU_Result_in, a0_in, a7_in, EPCWriteData_in  in  WIDTH each  WB data fields
- IRS_in  in  3  one-hot source of the retiring Int_Enter
- irq_raw  in  3  external interrupt lines, synchronous to clk
- Int_Ack  in  1  front end accepted the current request
- RegWrite_out  out  1  register-file write enable
- WriteRegNo_out  out  5  = WriteRegNo_in
- WriteData_out  out  WIDTH  writeback data
- IE_out  out  1  interrupt-enable CSR
- EPC_out  out  WIDTH  exception PC CSR
- Int_Req  out  1  interrupt request to front end
- Int_Vec  out  WIDTH  handler address of requested source
- IRS_req  out  3  one-hot requested source
- halt_out  out  1  sticky halt
- print_valid  out  1  one-cycle print strobe
- print_data  out  WIDTH  value to print

## Operation
- Reset values: IE_out=1; EPC_out, Int_Vec, print_data=0; IRS_req=3'b000; Int_Req, halt_out, print_valid=0; pending, irq_prev and inflight=0.
- `commit` = en & ~halt_out.
- Writeback is combinational. WriteData_out = MemToReg_in ? MemData_in : ALU_Result_in. RegWrite_out = RegWrite_in & commit & (WriteRegNo_in != 0).
- CSR commit happens when commit & CSRWrite_in:
  - IEWrite_in: IE_out <= IEWriteData_in.
  - EPCWrite_in: EPC_out <= EPCWriteData_in.
  - Upstream encodes Int_Enter (IE=0, EPC=PC) and uret (IE=1); this block applies the fields verbatim.
- Ecall, when commit & ecall_in:
  - a7_in==10: halt_out <= 1. halt_out clears only on rst.
  - Otherwise: print_valid <= 1 and print_data <= a0_in.
  - print_valid is 0 in every other cycle.
- Edge capture: irq_prev <= irq_raw every cycle. rise = irq_raw & ~irq_prev. pending <= (pending & ~clr) | rise, where clr = IRS_in when commit & Int_Enter_in, else 0. If rise and clr hit the same bit in one cycle, the bit stays set.
- Priority: bit 2 highest, bit 0 lowest. Index i maps to Int_Vec = VEC_BASE + i*VEC_STRIDE (WIDTH-bit, wraps modulo 2^WIDTH).
- Request handshake:
  - Idle: Int_Req=0. On each edge, if IE_out & |pending & ~inflight & ~halt_out, register Int_Req=1, IRS_req=highest pending, Int_Vec=its vector.
  - Requesting: Int_Req, IRS_req and Int_Vec hold stable until a cycle with Int_Ack=1. On that edge Int_Req<=0 and inflight<=1. A higher-priority arrival while Int_Req=1 does not change the request.
  - Inflight: no new request. inflight<=0 when commit & (Int_Enter_in | uret_in).
  - Clearing IE while Int_Req=1 does not withdraw the request. The front end must ack it.
- IRS_req returns to 0 when Int_Req drops.

## Timing
- Writeback path: zero latency, combinational from the inputs.
- CSR values and halt_out are visible on the cycle after the commit edge.
- Interrupt latency: irq_raw rises before edge k, pending is set at edge k, Int_Req is high after edge k+1 (two edges), provided the request conditions hold at edge k+1.
- A reset asserted at any time forces all reset values immediately, including mid-handshake.
- While en=0, pending capture and handshake still run. Only commits are blocked.

## Test plan
- Writeback: WriteRegNo_in=5, RegWrite_in=1, MemToReg_in=0, ALU_Result_in=0x1234 -> RegWrite_out=1, WriteData_out=0x1234. With MemToReg_in=1 and MemData_in=0xBEEF -> WriteData_out=0xBEEF. With WriteRegNo_in=0 -> RegWrite_out=0.
- Single IRQ: irq_raw[1] rises before edge k -> after edge k+1, Int_Req=1, IRS_req=3'b010, Int_Vec=0x140. These hold for 5 cycles with Int_Ack=0. Ack -> Int_Req=0 next cycle. Int_Enter_in with IRS_in=010 and CSR fields (IE=0, EPC=0x80) -> IE_out=0, EPC_out=0x80, pending[1]=0.
- Priority: irq_raw[0] and irq_raw[2] rise together -> IRS_req=3'b100, Int_Vec=0x180. Ack, then Int_Enter retire, then uret retire (IE=1) -> next request IRS_req=3'b001, Int_Vec=0x100.
- IE gating: commit IEWrite with data 0, then irq_raw[0] rises -> Int_Req stays 0 for 10 cycles. Write IE=1 -> Int_Req=1 one edge later.
- Ecall: a7=1, a0=0x2A -> print_valid=1 for exactly one cycle, print_data=0x2A. Then a7=10 -> halt_out=1. A later RegWrite_in=1 gives RegWrite_out=0 and a new irq gives no Int_Req.
- Reset mid-request: assert rst while Int_Req=1 -> all outputs take reset values before the next clock edge.
